// File: rtl/l2_arb_pkg.sv
// Shared constants and encodings for the L2 port arbiter: FSM states, transaction owners and
// default line geometry.
package l2_arb_pkg;

    localparam int unsigned ADDRESS_WIDTH  = 32;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned BLOCK_SIZE     = 32;
    localparam int unsigned OFFSET_WIDTH   = $clog2(DATA_WIDTH * BLOCK_SIZE / 8);
    localparam int unsigned BLK_ADDR_WIDTH = ADDRESS_WIDTH - OFFSET_WIDTH;
    localparam int unsigned CACHE_WIDTH    = BLOCK_SIZE * DATA_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        OWN_I   = 2'd0,
        OWN_DRD = 2'd1,
        OWN_DWB = 2'd2
    } owner_e;

    // Which cache won the most recent grant; drives the tie-break between caches.
    localparam logic GRANT_ICACHE = 1'b0;
    localparam logic GRANT_DCACHE = 1'b1;

endpackage

// File: rtl/l2_req_slot.sv
// One pending-request slot: latches a one-cycle request pulse (address, optionally a line) and
// flags a pulse that arrives while the slot is still occupied.
module l2_req_slot #(
    parameter int unsigned AddrWidth = 25,
    parameter int unsigned DataWidth = 1,
    parameter bit          HasData   = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 clear_i,
    output logic                 pending_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 dup_o
);

    logic                 pending_q, pending_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 accept;

    // A pulse coinciding with the grant of the previous request refills the slot.
    assign accept = valid_i & (~pending_q | clear_i);
    assign dup_o  = valid_i & pending_q & ~clear_i;

    always_comb begin
        pending_d = pending_q;
        addr_d    = addr_q;
        if (clear_i) begin
            pending_d = 1'b0;
        end
        if (accept) begin
            pending_d = 1'b1;
            addr_d    = addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            pending_q <= pending_d;
            addr_q    <= addr_d;
        end
    end

    generate
        if (HasData) begin : g_data
            logic [DataWidth-1:0] data_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    data_q <= '0;
                end else if (accept) begin
                    data_q <= data_i;
                end
            end

            assign data_o = data_q;
        end else begin : g_no_data
            logic unused_data;

            assign unused_data = ^data_i;
            assign data_o      = '0;
        end
    endgenerate

    assign pending_o = pending_q;
    assign addr_o    = addr_q;

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the single L2 port between Icache refills and Dcache refills/writebacks, one
// transaction at a time, with alternating priority between the two caches.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned address_width  = ADDRESS_WIDTH,
    parameter int unsigned data_width     = DATA_WIDTH,
    parameter int unsigned block_size     = BLOCK_SIZE,
    localparam int unsigned offset_width   = $clog2(data_width * block_size / 8),
    localparam int unsigned blk_addr_width = address_width - offset_width,
    localparam int unsigned cache_width    = block_size * data_width
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      I_ADDR_VALID,
    input  logic [blk_addr_width-1:0] I_ADDR,
    output logic                      I_DATA_VALID,
    input  logic                      D_RD_VALID,
    input  logic [blk_addr_width-1:0] D_RD_ADDR,
    input  logic                      D_WB_VALID,
    input  logic [blk_addr_width-1:0] D_WB_ADDR,
    input  logic [cache_width-1:0]    D_WB_DATA,
    output logic                      D_DATA_VALID,
    output logic                      D_WB_DONE,
    output logic [cache_width-1:0]    DATA_TO_L1,
    output logic                      L2_ADDR_VALID,
    output logic                      L2_WRITE,
    output logic [blk_addr_width-1:0] L2_ADDR,
    output logic [cache_width-1:0]    L2_WDATA,
    input  logic                      L2_READY,
    input  logic                      L2_RDATA_VALID,
    input  logic [cache_width-1:0]    L2_RDATA,
    input  logic                      L2_WR_ACK,
    output logic                      PROTO_ERR
);

    logic [1:0]                state_q, state_d;
    owner_e                    owner_q, owner_d;
    logic                      last_grant_q, last_grant_d;
    logic                      l2_valid_q, l2_valid_d;
    logic                      l2_write_q, l2_write_d;
    logic [blk_addr_width-1:0] l2_addr_q, l2_addr_d;
    logic [cache_width-1:0]    l2_wdata_q, l2_wdata_d;
    logic [cache_width-1:0]    data_to_l1_q, data_to_l1_d;
    logic                      i_dv_q, i_dv_d;
    logic                      d_dv_q, d_dv_d;
    logic                      wb_done_q, wb_done_d;
    logic                      proto_err_q, proto_err_d;

    logic                      i_pend, drd_pend, dwb_pend;
    logic                      i_dup, drd_dup, dwb_dup;
    logic [blk_addr_width-1:0] i_addr, drd_addr, dwb_addr;
    logic [cache_width-1:0]    dwb_data;
    logic                      unused_i_data, unused_drd_data;

    logic i_work, d_work, pick_i, pick_d, grant;
    logic clr_i, clr_drd, clr_dwb, resp_any;

    l2_req_slot #(
        .AddrWidth(blk_addr_width),
        .DataWidth(1),
        .HasData  (1'b0)
    ) u_slot_i (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .valid_i  (I_ADDR_VALID),
        .addr_i   (I_ADDR),
        .data_i   (1'b0),
        .clear_i  (clr_i),
        .pending_o(i_pend),
        .addr_o   (i_addr),
        .data_o   (unused_i_data),
        .dup_o    (i_dup)
    );

    l2_req_slot #(
        .AddrWidth(blk_addr_width),
        .DataWidth(1),
        .HasData  (1'b0)
    ) u_slot_drd (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .valid_i  (D_RD_VALID),
        .addr_i   (D_RD_ADDR),
        .data_i   (1'b0),
        .clear_i  (clr_drd),
        .pending_o(drd_pend),
        .addr_o   (drd_addr),
        .data_o   (unused_drd_data),
        .dup_o    (drd_dup)
    );

    l2_req_slot #(
        .AddrWidth(blk_addr_width),
        .DataWidth(cache_width),
        .HasData  (1'b1)
    ) u_slot_dwb (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .valid_i  (D_WB_VALID),
        .addr_i   (D_WB_ADDR),
        .data_i   (D_WB_DATA),
        .clear_i  (clr_dwb),
        .pending_o(dwb_pend),
        .addr_o   (dwb_addr),
        .data_o   (dwb_data),
        .dup_o    (dwb_dup)
    );

    // On a tie the cache that did not win last time goes first; the dirty victim beats the refill.
    assign i_work   = i_pend;
    assign d_work   = drd_pend | dwb_pend;
    assign pick_i   = i_work & (~d_work | (last_grant_q == GRANT_DCACHE));
    assign pick_d   = d_work & ~pick_i;
    assign grant    = (state_q == ST_IDLE) & (i_work | d_work);
    assign clr_i    = grant & pick_i;
    assign clr_dwb  = grant & pick_d & dwb_pend;
    assign clr_drd  = grant & pick_d & ~dwb_pend;
    assign resp_any = L2_RDATA_VALID | L2_WR_ACK;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        l2_valid_d   = l2_valid_q;
        l2_write_d   = l2_write_q;
        l2_addr_d    = l2_addr_q;
        l2_wdata_d   = l2_wdata_q;
        data_to_l1_d = data_to_l1_q;
        i_dv_d       = 1'b0;
        d_dv_d       = 1'b0;
        wb_done_d    = 1'b0;
        proto_err_d  = proto_err_q | i_dup | drd_dup | dwb_dup;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d    = ST_ISSUE;
                    l2_valid_d = 1'b1;
                    if (clr_i) begin
                        owner_d      = OWN_I;
                        last_grant_d = GRANT_ICACHE;
                        l2_write_d   = 1'b0;
                        l2_addr_d    = i_addr;
                        l2_wdata_d   = '0;
                    end else if (clr_dwb) begin
                        owner_d      = OWN_DWB;
                        last_grant_d = GRANT_DCACHE;
                        l2_write_d   = 1'b1;
                        l2_addr_d    = dwb_addr;
                        l2_wdata_d   = dwb_data;
                    end else begin
                        owner_d      = OWN_DRD;
                        last_grant_d = GRANT_DCACHE;
                        l2_write_d   = 1'b0;
                        l2_addr_d    = drd_addr;
                        l2_wdata_d   = '0;
                    end
                end
                if (resp_any) begin
                    proto_err_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (L2_READY) begin
                    l2_valid_d = 1'b0;
                    state_d    = ST_WAIT;
                end
                if (resp_any) begin
                    proto_err_d = 1'b1;
                end
            end
            ST_WAIT: begin
                // A response of the wrong kind is flagged and the transaction keeps waiting.
                if (owner_q == OWN_DWB) begin
                    if (L2_WR_ACK) begin
                        wb_done_d = 1'b1;
                        state_d   = ST_RESP;
                    end
                    if (L2_RDATA_VALID) begin
                        proto_err_d = 1'b1;
                    end
                end else begin
                    if (L2_RDATA_VALID) begin
                        data_to_l1_d = L2_RDATA;
                        i_dv_d       = (owner_q == OWN_I);
                        d_dv_d       = (owner_q == OWN_DRD);
                        state_d      = ST_RESP;
                    end
                    if (L2_WR_ACK) begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (resp_any) begin
                    proto_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= GRANT_DCACHE;
            l2_valid_q   <= 1'b0;
            l2_write_q   <= 1'b0;
            l2_addr_q    <= '0;
            l2_wdata_q   <= '0;
            data_to_l1_q <= '0;
            i_dv_q       <= 1'b0;
            d_dv_q       <= 1'b0;
            wb_done_q    <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            l2_valid_q   <= l2_valid_d;
            l2_write_q   <= l2_write_d;
            l2_addr_q    <= l2_addr_d;
            l2_wdata_q   <= l2_wdata_d;
            data_to_l1_q <= data_to_l1_d;
            i_dv_q       <= i_dv_d;
            d_dv_q       <= d_dv_d;
            wb_done_q    <= wb_done_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign I_DATA_VALID  = i_dv_q;
    assign D_DATA_VALID  = d_dv_q;
    assign D_WB_DONE     = wb_done_q;
    assign DATA_TO_L1    = data_to_l1_q;
    assign L2_ADDR_VALID = l2_valid_q;
    assign L2_WRITE      = l2_write_q;
    assign L2_ADDR       = l2_addr_q;
    assign L2_WDATA      = l2_wdata_q;
    assign PROTO_ERR     = proto_err_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the pending requests and the fairness rule.
module tb_l2_port_arbiter;

    localparam int AW = 25;
    localparam int CW = 1024;

    logic          CLK, RST;
    logic          I_ADDR_VALID, D_RD_VALID, D_WB_VALID;
    logic [AW-1:0] I_ADDR, D_RD_ADDR, D_WB_ADDR;
    logic [CW-1:0] D_WB_DATA;
    logic          I_DATA_VALID, D_DATA_VALID, D_WB_DONE;
    logic [CW-1:0] DATA_TO_L1;
    logic          L2_ADDR_VALID, L2_WRITE;
    logic [AW-1:0] L2_ADDR;
    logic [CW-1:0] L2_WDATA;
    logic          L2_READY, L2_RDATA_VALID, L2_WR_ACK;
    logic [CW-1:0] L2_RDATA;
    logic          PROTO_ERR;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations captured by the L2-side driver tasks.
    bit            obs_to, obs_stable, obs_dropped, obs_extra;
    int            obs_wait;
    logic          obs_write, obs_idv, obs_ddv, obs_wbd;
    logic [AW-1:0] obs_addr;
    logic [CW-1:0] obs_wdata, obs_data;

    // Reference model: pending set per source (0 = I rd, 1 = D rd, 2 = D wb) and last winner.
    bit   [2:0]    m_pend;
    logic [AW-1:0] m_addr [3];
    logic [CW-1:0] m_wdata;
    bit            m_last_d;

    l2_port_arbiter dut (
        .CLK           (CLK),
        .RST           (RST),
        .I_ADDR_VALID  (I_ADDR_VALID),
        .I_ADDR        (I_ADDR),
        .I_DATA_VALID  (I_DATA_VALID),
        .D_RD_VALID    (D_RD_VALID),
        .D_RD_ADDR     (D_RD_ADDR),
        .D_WB_VALID    (D_WB_VALID),
        .D_WB_ADDR     (D_WB_ADDR),
        .D_WB_DATA     (D_WB_DATA),
        .D_DATA_VALID  (D_DATA_VALID),
        .D_WB_DONE     (D_WB_DONE),
        .DATA_TO_L1    (DATA_TO_L1),
        .L2_ADDR_VALID (L2_ADDR_VALID),
        .L2_WRITE      (L2_WRITE),
        .L2_ADDR       (L2_ADDR),
        .L2_WDATA      (L2_WDATA),
        .L2_READY      (L2_READY),
        .L2_RDATA_VALID(L2_RDATA_VALID),
        .L2_RDATA      (L2_RDATA),
        .L2_WR_ACK     (L2_WR_ACK),
        .PROTO_ERR     (PROTO_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    function automatic logic [CW-1:0] rand_line();
        logic [CW-1:0] l;
        for (int i = 0; i < CW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic clear_inputs();
        I_ADDR_VALID = 0; D_RD_VALID = 0; D_WB_VALID = 0;
        I_ADDR = '0; D_RD_ADDR = '0; D_WB_ADDR = '0; D_WB_DATA = '0;
        L2_READY = 0; L2_RDATA_VALID = 0; L2_WR_ACK = 0; L2_RDATA = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        RST = 0;
        repeat (2) tick();
        RST = 1;
        tick();
        m_pend = '0; m_last_d = 1'b1;
    endtask

    task automatic pulse3(input bit pi, input logic [AW-1:0] ai, input bit pr,
                          input logic [AW-1:0] ar, input bit pw, input logic [AW-1:0] aw,
                          input logic [CW-1:0] dw);
        I_ADDR_VALID = pi; I_ADDR = ai;
        D_RD_VALID = pr; D_RD_ADDR = ar;
        D_WB_VALID = pw; D_WB_ADDR = aw; D_WB_DATA = dw;
        tick();
        I_ADDR_VALID = 0; D_RD_VALID = 0; D_WB_VALID = 0;
    endtask

    // Waits (bounded) for a request, stalls it ready_delay cycles, then accepts it.
    task automatic l2_accept(input int ready_delay, input int inject_at,
                             input logic [AW-1:0] inject_addr);
        obs_to = 1; obs_wait = 0; obs_stable = 1; obs_dropped = 0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (L2_ADDR_VALID === 1'b1) begin
                obs_to = 0; obs_wait = k;
                break;
            end
        end
        if (obs_to) return;
        obs_write = L2_WRITE; obs_addr = L2_ADDR; obs_wdata = L2_WDATA;
        for (int j = 0; j < ready_delay; j++) begin
            I_ADDR_VALID = (j == inject_at);
            if (j == inject_at) I_ADDR = inject_addr;
            tick();
            I_ADDR_VALID = 0;
            if (L2_ADDR_VALID !== 1'b1 || L2_WRITE !== obs_write || L2_ADDR !== obs_addr ||
                L2_WDATA !== obs_wdata) obs_stable = 0;
        end
        L2_READY = 1;
        tick();
        L2_READY = 0;
        obs_dropped = (L2_ADDR_VALID === 1'b0);
    endtask

    task automatic l2_respond(input bit wr, input int delay, input logic [CW-1:0] rdata);
        repeat (delay) tick();
        if (wr) L2_WR_ACK = 1;
        else begin
            L2_RDATA_VALID = 1; L2_RDATA = rdata;
        end
        tick();
        L2_WR_ACK = 0; L2_RDATA_VALID = 0;
        obs_idv = I_DATA_VALID; obs_ddv = D_DATA_VALID; obs_wbd = D_WB_DONE;
        obs_data = DATA_TO_L1;
        tick();
        obs_extra = I_DATA_VALID | D_DATA_VALID | D_WB_DONE;
    endtask

    function automatic int model_pick();
        bit i_has, d_has;
        i_has = m_pend[0];
        d_has = m_pend[1] | m_pend[2];
        if (i_has && (!d_has || m_last_d)) return 0;
        return m_pend[2] ? 2 : 1;
    endfunction

    task automatic rand_pulses(input bit force_one);
        bit [2:0]      sel;
        logic [AW-1:0] a [3];
        logic [CW-1:0] d;
        do sel = 3'($urandom_range(0, 7)) & ~m_pend; while (force_one && sel == 3'b000);
        for (int i = 0; i < 3; i++) a[i] = AW'($urandom);
        d = rand_line();
        for (int i = 0; i < 3; i++) if (sel[i]) begin
            m_pend[i] = 1'b1; m_addr[i] = a[i];
        end
        if (sel[2]) m_wdata = d;
        pulse3(sel[0], a[0], sel[1], a[1], sel[2], a[2], d);
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1;
        #2 RST = 0;
        #1;
        n_checks++; if ({I_DATA_VALID, D_DATA_VALID, D_WB_DONE, L2_ADDR_VALID, L2_WRITE, PROTO_ERR} !== 6'b0) $display("FAIL reset.flags: got %b want 000000", {I_DATA_VALID, D_DATA_VALID, D_WB_DONE, L2_ADDR_VALID, L2_WRITE, PROTO_ERR}); else n_pass++;
        n_checks++; if (L2_ADDR !== '0) $display("FAIL reset.l2_addr: got %0h want 0", L2_ADDR); else n_pass++;
        n_checks++; if (L2_WDATA !== '0) $display("FAIL reset.l2_wdata: got %0h want 0", L2_WDATA[63:0]); else n_pass++;
        n_checks++; if (DATA_TO_L1 !== '0) $display("FAIL reset.data_to_l1: got %0h want 0", DATA_TO_L1[63:0]); else n_pass++;
        repeat (2) tick();
        RST = 1;
        repeat (3) tick();
        n_checks++; if (L2_ADDR_VALID !== 1'b0) $display("FAIL reset.idle_after_release: got %b want 0", L2_ADDR_VALID); else n_pass++;
    endtask

    task automatic test_single_refill();
        logic [CW-1:0] line;
        line = {32{32'hDEADBEEF}};
        apply_reset();
        pulse3(1, 25'h0000200, 0, '0, 0, '0, '0);
        l2_accept(0, -1, '0);
        n_checks++; if (obs_to !== 1'b0) $display("FAIL single.timeout: got %b want 0", obs_to); else n_pass++;
        n_checks++; if (obs_wait !== 1) $display("FAIL single.latency: got %0d want 1", obs_wait); else n_pass++;
        n_checks++; if (obs_addr !== 25'h0000200) $display("FAIL single.addr: got %0h want 200", obs_addr); else n_pass++;
        n_checks++; if (obs_write !== 1'b0) $display("FAIL single.write: got %b want 0", obs_write); else n_pass++;
        n_checks++; if (obs_dropped !== 1'b1) $display("FAIL single.valid_one_cycle: got %b want 1", obs_dropped); else n_pass++;
        l2_respond(0, 3, line);
        n_checks++; if ({obs_idv, obs_ddv, obs_wbd} !== 3'b100) $display("FAIL single.pulses: got %b want 100", {obs_idv, obs_ddv, obs_wbd}); else n_pass++;
        n_checks++; if (obs_data !== line) $display("FAIL single.data: got %0h want %0h", obs_data[63:0], line[63:0]); else n_pass++;
        n_checks++; if (obs_extra !== 1'b0) $display("FAIL single.pulse_width: got %b want 0", obs_extra); else n_pass++;
        repeat (3) tick();
        n_checks++; if (DATA_TO_L1 !== line) $display("FAIL single.data_hold: got %0h want %0h", DATA_TO_L1[63:0], line[63:0]); else n_pass++;
        n_checks++; if (PROTO_ERR !== 1'b0) $display("FAIL single.proto_err: got %b want 0", PROTO_ERR); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [CW-1:0] la, lb;
        la = rand_line(); lb = rand_line();
        apply_reset();
        pulse3(1, 25'h10, 1, 25'h20, 0, '0, '0);
        l2_accept(0, -1, '0);
        n_checks++; if (obs_to !== 1'b0 || obs_addr !== 25'h10) $display("FAIL simul.first_addr: got %0h (to=%b) want 10", obs_addr, obs_to); else n_pass++;
        l2_respond(0, 1, la);
        n_checks++; if ({obs_idv, obs_ddv} !== 2'b10) $display("FAIL simul.first_pulse: got %b want 10", {obs_idv, obs_ddv}); else n_pass++;
        l2_accept(0, -1, '0);
        n_checks++; if (obs_to !== 1'b0 || obs_addr !== 25'h20) $display("FAIL simul.second_addr: got %0h (to=%b) want 20", obs_addr, obs_to); else n_pass++;
        n_checks++; if (obs_wait !== 1) $display("FAIL simul.bubble: got %0d want 1", obs_wait); else n_pass++;
        l2_respond(0, 1, lb);
        n_checks++; if ({obs_idv, obs_ddv} !== 2'b01) $display("FAIL simul.second_pulse: got %b want 01", {obs_idv, obs_ddv}); else n_pass++;
        n_checks++; if (obs_data !== lb) $display("FAIL simul.data: got %0h want %0h", obs_data[63:0], lb[63:0]); else n_pass++;
    endtask

    task automatic test_wb_before_rd();
        logic [CW-1:0] line;
        line = {128{8'h5A}};
        apply_reset();
        pulse3(0, '0, 1, 25'h40, 1, 25'h30, line);
        l2_accept(0, -1, '0);
        n_checks++; if (obs_to !== 1'b0 || obs_write !== 1'b1) $display("FAIL wb.write: got %b (to=%b) want 1", obs_write, obs_to); else n_pass++;
        n_checks++; if (obs_addr !== 25'h30) $display("FAIL wb.addr: got %0h want 30", obs_addr); else n_pass++;
        n_checks++; if (obs_wdata !== line) $display("FAIL wb.wdata: got %0h want %0h", obs_wdata[63:0], line[63:0]); else n_pass++;
        l2_respond(1, 2, '0);
        n_checks++; if ({obs_idv, obs_ddv, obs_wbd} !== 3'b001) $display("FAIL wb.done: got %b want 001", {obs_idv, obs_ddv, obs_wbd}); else n_pass++;
        l2_accept(0, -1, '0);
        n_checks++; if (obs_to !== 1'b0 || obs_write !== 1'b0 || obs_addr !== 25'h40) $display("FAIL wb.refill_next: got %0h w=%b want 40 w=0", obs_addr, obs_write); else n_pass++;
        l2_respond(0, 0, line);
        n_checks++; if ({obs_idv, obs_ddv, obs_wbd} !== 3'b010) $display("FAIL wb.refill_pulse: got %b want 010", {obs_idv, obs_ddv, obs_wbd}); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [CW-1:0] line;
        line = rand_line();
        apply_reset();
        pulse3(0, '0, 0, '0, 1, 25'h50, line);
        l2_accept(5, 2, 25'h77);
        n_checks++; if (obs_to !== 1'b0 || obs_stable !== 1'b1) $display("FAIL bp.stable: got %b (to=%b) want 1", obs_stable, obs_to); else n_pass++;
        n_checks++; if (obs_addr !== 25'h50 || obs_wdata !== line) $display("FAIL bp.fields: got %0h want 50", obs_addr); else n_pass++;
        n_checks++; if (obs_dropped !== 1'b1) $display("FAIL bp.drop_on_ready: got %b want 1", obs_dropped); else n_pass++;
        l2_respond(1, 1, '0);
        n_checks++; if (obs_wbd !== 1'b1) $display("FAIL bp.wb_done: got %b want 1", obs_wbd); else n_pass++;
        l2_accept(0, -1, '0);
        n_checks++; if (obs_to !== 1'b0 || obs_addr !== 25'h77 || obs_wait !== 1) $display("FAIL bp.held_i: got %0h wait=%0d want 77 wait=1", obs_addr, obs_wait); else n_pass++;
        l2_respond(0, 0, line);
        n_checks++; if (obs_idv !== 1'b1) $display("FAIL bp.i_pulse: got %b want 1", obs_idv); else n_pass++;
    endtask

    task automatic test_fairness();
        logic [AW-1:0] ia, da;
        bit            exp_i;
        ia = 25'h100; da = 25'h200;
        apply_reset();
        pulse3(1, ia, 1, da, 0, '0, '0);
        for (int n = 0; n < 6; n++) begin
            exp_i = (n % 2 == 0);
            l2_accept(0, -1, '0);
            n_checks++; if (obs_to !== 1'b0 || obs_addr !== (exp_i ? ia : da)) $display("FAIL fair.grant%0d: got %0h want %0h", n, obs_addr, exp_i ? ia : da); else n_pass++;
            l2_respond(0, n % 3, rand_line());
            n_checks++; if ({obs_idv, obs_ddv} !== {exp_i, !exp_i}) $display("FAIL fair.pulse%0d: got %b want %b", n, {obs_idv, obs_ddv}, {exp_i, !exp_i}); else n_pass++;
            if (exp_i) begin
                ia = ia + 1; pulse3(1, ia, 0, '0, 0, '0, '0);
            end else begin
                da = da + 1; pulse3(0, '0, 1, da, 0, '0, '0);
            end
        end
    endtask

    task automatic test_errors();
        logic [CW-1:0] line;
        bit            seen_valid;
        line = rand_line();
        // Duplicate pulse while the I request waits behind a D refill.
        apply_reset();
        pulse3(0, '0, 1, 25'h70, 0, '0, '0);
        tick();
        pulse3(1, 25'h61, 0, '0, 0, '0, '0);
        n_checks++; if (PROTO_ERR !== 1'b0) $display("FAIL err.no_false_flag: got %b want 0", PROTO_ERR); else n_pass++;
        pulse3(1, 25'h62, 0, '0, 0, '0, '0);
        n_checks++; if (PROTO_ERR !== 1'b1) $display("FAIL err.dup_flag: got %b want 1", PROTO_ERR); else n_pass++;
        l2_accept(0, -1, '0);
        l2_respond(0, 0, line);
        l2_accept(0, -1, '0);
        n_checks++; if (obs_to !== 1'b0 || obs_addr !== 25'h61) $display("FAIL err.dup_dropped: got %0h want 61", obs_addr); else n_pass++;
        l2_respond(0, 0, line);
        // Stray refill data in IDLE.
        apply_reset();
        L2_RDATA_VALID = 1; L2_RDATA = line;
        tick();
        L2_RDATA_VALID = 0;
        n_checks++; if (PROTO_ERR !== 1'b1) $display("FAIL err.stray_flag: got %b want 1", PROTO_ERR); else n_pass++;
        n_checks++; if ({I_DATA_VALID, D_DATA_VALID} !== 2'b00 || DATA_TO_L1 !== '0) $display("FAIL err.stray_ignored: got %b want 00", {I_DATA_VALID, D_DATA_VALID}); else n_pass++;
        // Write ack while a refill is outstanding.
        apply_reset();
        pulse3(1, 25'h71, 0, '0, 0, '0, '0);
        l2_accept(0, -1, '0);
        L2_WR_ACK = 1;
        tick();
        L2_WR_ACK = 0;
        n_checks++; if (PROTO_ERR !== 1'b1 || D_WB_DONE !== 1'b0) $display("FAIL err.mismatch: got err=%b done=%b want 1 0", PROTO_ERR, D_WB_DONE); else n_pass++;
        l2_respond(0, 0, line);
        n_checks++; if (obs_idv !== 1'b1) $display("FAIL err.mismatch_recover: got %b want 1", obs_idv); else n_pass++;
        // Reset asserted mid-transaction with another request pending.
        apply_reset();
        pulse3(1, 25'h80, 0, '0, 0, '0, '0);
        l2_accept(0, -1, '0);
        pulse3(0, '0, 1, 25'h90, 0, '0, '0);
        #2 RST = 0;
        #1;
        n_checks++; if (L2_ADDR !== '0 || L2_ADDR_VALID !== 1'b0) $display("FAIL err.async_reset: got addr=%0h v=%b want 0 0", L2_ADDR, L2_ADDR_VALID); else n_pass++;
        tick();
        RST = 1;
        seen_valid = 0;
        repeat (4) begin
            tick();
            if (L2_ADDR_VALID !== 1'b0) seen_valid = 1;
        end
        n_checks++; if (seen_valid !== 1'b0) $display("FAIL err.flags_cleared: got %b want 0", seen_valid); else n_pass++;
        L2_RDATA_VALID = 1;
        tick();
        L2_RDATA_VALID = 0;
        n_checks++; if (I_DATA_VALID !== 1'b0 || PROTO_ERR !== 1'b1) $display("FAIL err.reset_to_idle: got idv=%b err=%b want 0 1", I_DATA_VALID, PROTO_ERR); else n_pass++;
    endtask

    task automatic test_random();
        int            exp;
        logic [CW-1:0] line;
        apply_reset();
        for (int t = 0; t < 40; t++) begin
            if (m_pend == 3'b000) rand_pulses(1);
            l2_accept($urandom_range(0, 3), -1, '0);
            n_checks++; if (obs_to !== 1'b0) begin
                $display("FAIL rand.timeout%0d: got no request want one", t);
                return;
            end else n_pass++;
            exp = model_pick();
            n_checks++; if (obs_write !== (exp == 2) || obs_addr !== m_addr[exp]) $display("FAIL rand.grant%0d: got %0h w=%b want %0h src=%0d", t, obs_addr, obs_write, m_addr[exp], exp); else n_pass++;
            if (exp == 2) begin
                n_checks++; if (obs_wdata !== m_wdata) $display("FAIL rand.wdata%0d: got %0h want %0h", t, obs_wdata[63:0], m_wdata[63:0]); else n_pass++;
            end
            m_pend[exp] = 1'b0;
            m_last_d = (exp != 0);
            rand_pulses(0);
            line = rand_line();
            l2_respond(exp == 2, $urandom_range(0, 3), line);
            n_checks++; if ({obs_idv, obs_ddv, obs_wbd} !== {exp == 0, exp == 1, exp == 2} || obs_extra !== 1'b0) $display("FAIL rand.resp%0d: got %b extra=%b src=%0d", t, {obs_idv, obs_ddv, obs_wbd}, obs_extra, exp); else n_pass++;
            if (exp != 2) begin
                n_checks++; if (obs_data !== line) $display("FAIL rand.data%0d: got %0h want %0h", t, obs_data[63:0], line[63:0]); else n_pass++;
            end
        end
        n_checks++; if (PROTO_ERR !== 1'b0) $display("FAIL rand.proto_err: got %b want 0", PROTO_ERR); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_refill();
        test_simultaneous();
        test_wb_before_rd();
        test_backpressure();
        test_fairness();
        test_errors();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
